// File: rtl/mts_pkg.sv
// Shared definitions for the load/store-multiple sequencer: FSM state encoding.
package mts_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ISSUE = 2'd1;
    localparam state_t ST_DONE  = 2'd2;

endpackage

// File: rtl/mts_prio_enc.sv
// Combinational set-bit finder: lowest set bit when ascending, highest when descending.
module mts_prio_enc #(
    parameter int NREGS = 8,
    parameter int IW    = $clog2(NREGS)
) (
    input  logic [NREGS-1:0] mask,
    input  logic             desc,
    output logic [IW-1:0]    idx,
    output logic             any
);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        idx = '0;
        if (desc) begin
            // The last match wins, so scan upward to land on the highest set bit.
            for (int i = 0; i < NREGS; i++) begin
                if (mask[i]) idx = IW'(i);
            end
        end else begin
            for (int i = NREGS - 1; i >= 0; i--) begin
                if (mask[i]) idx = IW'(i);
            end
        end
    end

    assign any = |mask;

endmodule

// File: rtl/multi_transfer_seq.sv
// Load/store-multiple sequencer: walks a register mask, moving one register per
// memory req/ack handshake, ascending or descending from a base address.
module multi_transfer_seq
    import mts_pkg::*;
#(
    parameter int NREGS = 8,
    parameter int AW    = 16,
    parameter int DW    = 16,
    parameter int IW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             proc_rst,
    input  logic             start,
    input  logic             is_store,
    input  logic             desc,
    input  logic [NREGS-1:0] mask,
    input  logic [AW-1:0]    base_addr,
    output logic             busy,
    output logic             done,
    output logic [IW:0]      count,
    output logic [AW-1:0]    final_addr,
    output logic             mem_req,
    output logic             mem_we,
    output logic [AW-1:0]    mem_addr,
    output logic [DW-1:0]    mem_wdata,
    input  logic             mem_ack,
    input  logic [DW-1:0]    mem_rdata,
    output logic [IW-1:0]    rf_raddr,
    input  logic [DW-1:0]    rf_rdata,
    output logic             rf_we,
    output logic [IW-1:0]    rf_waddr,
    output logic [DW-1:0]    rf_wdata
);

    state_t           state;
    logic [NREGS-1:0] rem_mask;
    logic [NREGS-1:0] mask_clr;
    logic [AW-1:0]    addr;
    logic [AW-1:0]    addr_step;
    logic             store_q;
    logic             desc_q;
    logic [IW-1:0]    idx;
    logic             any;

    mts_prio_enc #(.NREGS(NREGS), .IW(IW)) u_prio_enc (
        .mask (rem_mask),
        .desc (desc_q),
        .idx  (idx),
        .any  (any)
    );

    always_comb begin
        mask_clr      = rem_mask;
        mask_clr[idx] = 1'b0;
    end

    assign addr_step = desc_q ? addr - AW'(1) : addr + AW'(1);

    // Request outputs are gated by state so an asynchronous reset zeroes them at once.
    assign mem_req    = (state == ST_ISSUE) && any;
    assign mem_we     = mem_req && store_q;
    assign mem_addr   = mem_req ? addr : '0;
    assign mem_wdata  = mem_req ? rf_rdata : '0;
    assign rf_raddr   = mem_req ? idx : '0;
    assign busy       = (state == ST_ISSUE) || (state == ST_DONE);
    assign done       = (state == ST_DONE);
    // The address register stops moving after the last ack, so it is the end address.
    assign final_addr = addr;

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge proc_rst) begin
        if (!proc_rst) begin
            state    <= ST_IDLE;
            rem_mask <= '0;
            addr     <= '0;
            store_q  <= 1'b0;
            desc_q   <= 1'b0;
            count    <= '0;
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            rf_we <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        rem_mask <= mask;
                        addr     <= base_addr;
                        store_q  <= is_store;
                        desc_q   <= desc;
                        count    <= '0;
                        state    <= (|mask) ? ST_ISSUE : ST_DONE;
                    end
                end
                ST_ISSUE: begin
                    if (mem_req && mem_ack) begin
                        rem_mask <= mask_clr;
                        addr     <= addr_step;
                        count    <= count + (IW + 1)'(1);
                        if (!store_q) begin
                            rf_we    <= 1'b1;
                            rf_waddr <= idx;
                            rf_wdata <= mem_rdata;
                        end
                        if (!(|mask_clr)) state <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/multi_transfer_seq.md
# multi_transfer_seq

Parametrised load-multiple / store-multiple sequencer that walks a register mask and moves one register per memory handshake. It sits between the main multicycle controller and the register file / data memory: the controller hands it a mask, base address and direction, then waits for `done`. It succeeds the fixed 8-register LM/SM sequencing with:
- configurable register count and widths,
- a req/ack memory handshake with wait states,
- ascending or descending addressing,
- a transfer count report.

## Interface
Parameters:
- `NREGS`, 8, number of architectural registers (mask width); power of 2, ≥2.
- `AW`, 16, memory address width.
- `DW`, 16, data width.
- `IW`, log2(NREGS), register index width (derived).

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `proc_rst` in 1: reset, asynchronous, active-low.
- `start` in 1: begin a sequence; sampled only in IDLE.
- `is_store` in 1: 1 = SM (register→memory), 0 = LM (memory→register).
- `desc` in 1: 0 = ascending (lowest index first, address +1); 1 = descending (highest index first, address −1).
- `mask` in NREGS: registers to transfer.
- `base_addr` in AW: first address.
- `busy` out 1: sequence in progress (ISSUE or DONE).
- `done` out 1: one-cycle completion pulse.
- `count` out IW+1: transfers completed in the current or last sequence.
- `final_addr` out AW: address after the last transfer.
- `mem_req` out 1, `mem_we` out 1, `mem_addr` out AW, `mem_wdata` out DW.
- `mem_ack` in 1, `mem_rdata` in DW: valid in the `mem_ack` cycle.
- `rf_raddr` out IW, `rf_rdata` in DW: combinational register-file read.
- `rf_we` out 1, `rf_waddr` out IW, `rf_wdata` out DW.

## Operation
States: IDLE, ISSUE, DONE.

- **IDLE**
  - `start`=1 latches `mask`, `base_addr`, `is_store` and `desc`, and clears `count`.
  - Latched mask ≠0 → ISSUE. Latched mask =0 → DONE directly, with no memory traffic.
  - `start` is ignored when not in IDLE.
- **ISSUE**
  - `idx` = priority-encoded lowest set bit of the remaining mask (`desc`=0) or highest set bit (`desc`=1).
  - Drive `mem_req`=1, `mem_addr`=current address, `mem_we`=`is_store`, `rf_raddr`=`idx`, `mem_wdata`=`rf_rdata`.
  - All of these hold stable until `mem_ack`.
  - On an ack cycle:
    - clear bit `idx`;
    - `count` += 1;
    - address ± 1 (modulo 2^AW, wraps silently);
    - for LM, register `rf_waddr`=`idx` and `rf_wdata`=`mem_rdata`, and pulse `rf_we` the following cycle;
    - if the remaining mask becomes 0 → DONE, else stay in ISSUE with the next index.
- **DONE**
  - `done`=1, `busy`=1 for exactly one cycle, then → IDLE.
  - `final_addr` = base ± `count`, valid from DONE onward and held until the next `start`.
- **Reset** (`proc_rst`=0, any state, including mid-transfer)
  - Immediately: state=IDLE, latched mask=0, `count`=0, `final_addr`=0.
  - All outputs 0: `busy`, `done`, `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `rf_we`, `rf_waddr`, `rf_wdata`, `rf_raddr`.
  - No LM write-back is emitted for an ack that had not yet been captured when reset was asserted.

## Timing
- `start` sampled at edge E0 → `mem_req` high in the cycle after E0.
- With zero-wait ack (`mem_ack` high in the first `mem_req` cycle), one transfer completes per cycle. `mem_req` stays high back-to-back.
- For k transfers with w total wait cycles:
  - `busy` lasts k+w+1 cycles;
  - `done` is asserted in the cycle after the last ack.
- LM `rf_we` pulses lag their ack by 1 cycle. The final LM write coincides with the `done` cycle.
- SM: `rf_rdata` must be valid combinationally in every `mem_req` cycle.
- `mem_ack` while `mem_req`=0 is ignored.

## Structure
- Package `mts_pkg`: state enum (IDLE/ISSUE/DONE) and the encoding constants.
- Sub-module `mts_prio_enc` (parameter `NREGS`; inputs: mask, `desc`; outputs: `idx`, `any`): purely combinational lowest/highest set-bit encoder.

## Test plan
- LM, NREGS=8, mask=8'b1010_0101, base=0x0040, `desc`=0, zero-wait ack:
  - reads at 0x40,0x41,0x42,0x43;
  - `rf_we` to R0,R2,R5,R7 with the corresponding `mem_rdata`;
  - `done` 5 cycles after `start`; `count`=4; `final_addr`=0x0044.
- SM, mask=8'b0000_0110, base=0x0010, `desc`=1, ack delayed 2 cycles per request:
  - writes R2→0x10, then R1→0x0F;
  - `mem_addr`/`mem_wdata` stable while waiting;
  - `busy` 7 cycles; `final_addr`=0x000E.
- mask=0, `start` pulse: `done` in the next cycle, `mem_req` never asserted, `count`=0, `final_addr`=base.
- Wrap: base=0xFFFF, mask=8'b0000_0011, ascending: addresses 0xFFFF, then 0x0000; `final_addr`=0x0001.
- `proc_rst` low during the second transfer of a 4-transfer LM: all outputs 0 immediately, no further `rf_we`; new `start` after release runs a full sequence correctly.
- `start` asserted again while `busy`: ignored; the in-flight sequence completes unchanged.
